// File: rtl/noc_traffic_pkg.sv
// Shared definitions for the synthetic NoC traffic source: flit/mode codes, FSM states, flit field layout.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package noc_traffic_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        MODE_UNIFORM   = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_BITCOMP   = 2'd2,
        MODE_HOTSPOT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_DONE
    } state_e;

    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SEQ_LSB = 32;
    localparam int SEQ_W   = 16;
    localparam int WORD_W  = 32;

    // Header fields are packed downward from the MSB: type, dst_y, dst_x, src_y, src_x.
    function automatic int type_lsb(input int flit_w);
        return flit_w - 2;
    endfunction

    function automatic int dst_y_lsb(input int flit_w, input int mesh_y);
        return type_lsb(flit_w) - $clog2(mesh_y);
    endfunction

    function automatic int dst_x_lsb(input int flit_w, input int mesh_x, input int mesh_y);
        return dst_y_lsb(flit_w, mesh_y) - $clog2(mesh_x);
    endfunction

    function automatic int src_y_lsb(input int flit_w, input int mesh_x, input int mesh_y);
        return dst_x_lsb(flit_w, mesh_x, mesh_y) - $clog2(mesh_y);
    endfunction

    function automatic int src_x_lsb(input int flit_w, input int mesh_x, input int mesh_y);
        return src_y_lsb(flit_w, mesh_x, mesh_y) - $clog2(mesh_x);
    endfunction

endpackage

// File: rtl/noc_traffic_lfsr.sv
// 16-bit Galois LFSR, loaded with a per-node seed while reset is low, advancing every cycle.
// Latency: outputs are the current register value; new value each cycle.
// Backpressure: none, free-running.
module noc_traffic_lfsr
    import noc_traffic_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          RND_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      seed_mix,
    output logic [7:0]       dec_byte,
    output logic [RND_W-1:0] dst_bits
);

    logic [15:0] lfsr_q;
    logic [15:0] seed_raw;
    logic [15:0] seed_val;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    assign seed_raw = SEED ^ seed_mix;
    assign seed_val = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= seed_val;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign dec_byte = lfsr_q[7:0];
    assign dst_bits = lfsr_q[8 +: RND_W];

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node synthetic wormhole packet source; counters exist only with NOC_TRAFFIC_GEN_STATS_EN defined.
// Latency: head presented the cycle after the injection decision; one flit per cycle while push_ack is high.
// Backpressure: push/inject held until push_ack; j_full only blocks starting a new packet.
module noc_traffic_gen
    import noc_traffic_pkg::*;
#(
    parameter int          MESH_X  = 8,
    parameter int          MESH_Y  = 8,
    parameter int          FLIT_W  = 64,
    parameter int          MAX_LEN = 8,
    parameter int          HOT_X   = 0,
    parameter int          HOT_Y   = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(MESH_X)-1:0]  src_x,
    input  logic [$clog2(MESH_Y)-1:0]  src_y,
    input  logic                       en,
    input  logic                       end_sim,
    input  logic [1:0]                 mode,
    input  logic [7:0]                 rate,
    input  logic [$clog2(MAX_LEN):0]   pkt_len,
    input  logic                       j_full,
    output logic [FLIT_W-1:0]          inject,
    output logic                       push,
    input  logic                       push_ack,
    output logic                       done,
    output logic [31:0]                pkts_sent,
    output logic [31:0]                flits_sent,
    output logic [31:0]                stall_cycles
);

    localparam int XW       = $clog2(MESH_X);
    localparam int YW       = $clog2(MESH_Y);
    localparam int LW       = $clog2(MAX_LEN) + 1;
    localparam int TYPE_LSB = type_lsb(FLIT_W);
    localparam int DY_LSB   = dst_y_lsb(FLIT_W, MESH_Y);
    localparam int DX_LSB   = dst_x_lsb(FLIT_W, MESH_X, MESH_Y);
    localparam int SY_LSB   = src_y_lsb(FLIT_W, MESH_X, MESH_Y);
    localparam int SX_LSB   = src_x_lsb(FLIT_W, MESH_X, MESH_Y);

    state_e            state, state_nxt;
    logic [7:0]        dec_byte;
    logic [XW+YW-1:0]  dst_bits;
    logic [31:0]       cyc_cnt, ts_q;
    logic [15:0]       seq_q;
    logic [XW-1:0]     dst_x_q, cand_x;
    logic [YW-1:0]     dst_y_q, cand_y;
    logic [LW-1:0]     len_q, idx_q, len_eff;
    logic              done_q, decide, eligible, last_flit, latch, accept;
    flit_type_e        ftype;
    logic [FLIT_W-1:0] flit;

    noc_traffic_lfsr #(
        .SEED  (SEED),
        .RND_W (XW + YW)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .seed_mix (16'({src_y, src_x})),
        .dec_byte (dec_byte),
        .dst_bits (dst_bits)
    );

    assign decide    = (dec_byte < rate) || (rate == 8'hFF);
    assign push      = (state == ST_HEAD) || (state == ST_BODY);
    assign accept    = push && push_ack;
    assign last_flit = (idx_q == len_q - LW'(1));
    assign done      = done_q;

    // Destination candidate and eligibility for the pattern currently selected.
    always_comb begin
        cand_x   = dst_bits[XW-1:0];
        cand_y   = dst_bits[XW +: YW];
        eligible = 1'b1;
        case (mode_e'(mode))
            MODE_UNIFORM: begin
                if (cand_x == src_x && cand_y == src_y) cand_x[0] = ~cand_x[0];
            end
            MODE_TRANSPOSE: begin
                cand_x   = XW'(src_y);
                cand_y   = YW'(src_x);
                eligible = (XW'(src_y) != src_x);
            end
            MODE_BITCOMP: begin
                cand_x = ~src_x;
                cand_y = ~src_y;
            end
            default: begin
                cand_x   = XW'(HOT_X);
                cand_y   = YW'(HOT_Y);
                eligible = !(src_x == XW'(HOT_X) && src_y == YW'(HOT_Y));
            end
        endcase
    end

    always_comb begin
        if (pkt_len == '0)                   len_eff = LW'(1);
        else if (pkt_len > LW'(MAX_LEN))     len_eff = LW'(MAX_LEN);
        else                                 len_eff = pkt_len;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Inputs other than push_ack are only looked at in IDLE, so a started packet always completes.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (end_sim) begin
                    state_nxt = ST_DONE;
                end else if (en && !j_full && decide && eligible) begin
                    state_nxt = ST_HEAD;
                    latch     = 1'b1;
                end
            end
            ST_HEAD: if (push_ack) state_nxt = last_flit ? ST_IDLE : ST_BODY;
            ST_BODY: if (push_ack && last_flit) state_nxt = ST_IDLE;
            default: state_nxt = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ts_q    <= '0;
            seq_q   <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            len_q   <= LW'(1);
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            done_q  <= (state == ST_DONE);
            if (latch) begin
                dst_x_q <= cand_x;
                dst_y_q <= cand_y;
                len_q   <= len_eff;
                ts_q    <= cyc_cnt;
                idx_q   <= '0;
            end else if (accept) begin
                idx_q <= idx_q + LW'(1);
                if (last_flit) seq_q <= seq_q + 16'd1;
            end
        end
    end

    always_comb begin
        if (len_q == LW'(1))       ftype = FLIT_SINGLE;
        else if (state == ST_HEAD) ftype = FLIT_HEAD;
        else if (last_flit)        ftype = FLIT_TAIL;
        else                       ftype = FLIT_BODY;

        flit                       = '0;
        flit[TYPE_LSB +: 2]        = ftype;
        flit[DY_LSB +: YW]         = dst_y_q;
        flit[DX_LSB +: XW]         = dst_x_q;
        flit[SY_LSB +: YW]         = src_y;
        flit[SX_LSB +: XW]         = src_x;
        flit[SEQ_LSB +: SEQ_W]     = seq_q;
        flit[WORD_W-1:0]           = (state == ST_HEAD) ? ts_q : 32'(idx_q);
    end

    assign inject = push ? flit : '0;

`ifdef NOC_TRAFFIC_GEN_STATS_EN
    logic [31:0] pkts_q, flits_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkts_q  <= '0;
            flits_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept)              flits_q <= flits_q + 32'd1;
            if (accept && last_flit) pkts_q  <= pkts_q + 32'd1;
            if (push && !push_ack)   stall_q <= stall_q + 32'd1;
        end
    end

    assign pkts_sent    = pkts_q;
    assign flits_sent   = flits_q;
    assign stall_cycles = stall_q;
`else
    assign pkts_sent    = '0;
    assign flits_sent   = '0;
    assign stall_cycles = '0;
`endif

endmodule
